branch_predictor: RTL

- Fetch-stage dynamic branch predictor. It produces predict_pc, pred_taken and pred_count for the instruction at the current fetch PC.
- It is trained by the execute stage when a branch, jal or jalr resolves.
- It is the producer of the predict_pc/count pair that the pipeline flush logic later checks against the resolved pc_branch.
- It is a direct-mapped BTB, and each entry holds a 2-bit saturating counter.

---
 rtl/branch_predictor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters; optional stats via BP_STATS_EN
module branch_predictor #(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_f,
    output logic [31:0] predict_pc,
    output logic        pred_taken,
    output logic [1:0]  pred_count,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_jump,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
`ifdef BP_STATS_EN
    input  logic        upd_mispredict,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`else
    input  logic        upd_mispredict
`endif
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_LO  = IDX_BITS + 2;
    localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          cnt_q    [ENTRIES];
    logic                jmp_q    [ENTRIES];

    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic                f_hit;

    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit;

    logic                wr_en;
    logic [31:0]         wr_target;
    logic [1:0]          wr_cnt;
    logic                wr_jmp;

    assign f_idx = pc_f[IDX_BITS+1:2];
    assign f_tag = pc_f[TAG_HI:TAG_LO];
    assign u_idx = upd_pc[IDX_BITS+1:2];
    assign u_tag = upd_pc[TAG_HI:TAG_LO];

    // Lookup reads the registered tables only, so a same-cycle update is seen next cycle.
    always_comb begin
        f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken = f_hit && (jmp_q[f_idx] || cnt_q[f_idx][1]);
        pred_count = f_hit ? cnt_q[f_idx] : 2'b00;
        predict_pc = pred_taken ? target_q[f_idx] : (pc_f + 32'd4);
    end

    always_comb begin
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        wr_en     = 1'b0;
        wr_target = target_q[u_idx];
        wr_cnt    = cnt_q[u_idx];
        wr_jmp    = 1'b0;
        if (upd_valid) begin
            if (upd_is_jump) begin
                wr_en     = 1'b1;
                wr_target = upd_target;
                wr_cnt    = 2'b11;
                wr_jmp    = 1'b1;
            end else if (u_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    wr_target = upd_target;
                    wr_cnt    = (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'd1;
                end else begin
                    wr_cnt    = (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Not-taken misses never allocate; taken misses evict any alias.
                wr_en     = 1'b1;
                wr_target = upd_target;
                wr_cnt    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
                jmp_q[i]    <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= wr_target;
            cnt_q[u_idx]    <= wr_cnt;
            jmp_q[u_idx]    <= wr_jmp;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_updates_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_updates_q     <= '0;
            stat_mispredicts_q <= '0;
        end else if (upd_valid) begin
            stat_updates_q <= stat_updates_q + 32'd1;
            if (upd_mispredict) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_updates     = stat_updates_q;
    assign stat_mispredicts = stat_mispredicts_q;

    logic unused_bits;
    assign unused_bits = ^{pc_f[1:0], pc_f[31:TAG_HI+1], upd_pc[1:0], upd_pc[31:TAG_HI+1]};
`else
    logic unused_bits;
    assign unused_bits = ^{pc_f[1:0], pc_f[31:TAG_HI+1], upd_pc[1:0], upd_pc[31:TAG_HI+1],
                           upd_mispredict};
`endif

endmodule
